// File: rtl/risc_pkg.sv
// Shared definitions for the execute controller and the ALU it drives:
// opcodes, controller states and instruction field positions.
package risc_pkg;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_ASHL = 3'b001;
  localparam logic [2:0] OP_XNOR = 3'b010;
  localparam logic [2:0] OP_DIV2 = 3'b011;
  localparam logic [2:0] OP_MOV  = 3'b100;
  localparam logic [2:0] OP_LDI  = 3'b101;
  localparam logic [2:0] OP_NEG  = 3'b110;
  localparam logic [2:0] OP_OUT  = 3'b111;

  localparam int OP_MSB = 7;
  localparam int OP_LSB = 5;
  localparam int RD_MSB = 4;
  localparam int RD_LSB = 3;
  localparam int RS_MSB = 2;
  localparam int RS_LSB = 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_IMM  = 2'd1,
    S_EXEC = 2'd2,
    S_OUT  = 2'd3
  } state_t;

  // Arithmetic/logic ops update the carry flag; moves, loads and OUT leave it alone.
  function automatic logic op_sets_cf(input logic [2:0] op);
    return (op == OP_ADD) || (op == OP_ASHL) || (op == OP_XNOR) ||
           (op == OP_DIV2) || (op == OP_NEG);
  endfunction

endpackage

// File: rtl/reg_file_4x8.sv
// Small register file: two combinational read ports, one synchronous write
// port, cleared to zero by the asynchronous active-low reset.
module reg_file_4x8 #(
  parameter int NREGS = 4,
  parameter int W     = 8,
  parameter int AW    = $clog2(NREGS)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [AW-1:0] raddr_a,
  output logic [W-1:0]  rdata_a,
  input  logic [AW-1:0] raddr_b,
  output logic [W-1:0]  rdata_b,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata
);

  logic [W-1:0] mem [NREGS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) begin
        mem[i] <= '0;
      end
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata_a = mem[raddr_a];
  assign rdata_b = mem[raddr_b];

endmodule

// File: rtl/exec_ctrl.sv
// Multi-cycle execute controller: fetches an instruction (and optional
// immediate), drives the external ALU for one cycle, then writes back or outputs.
module exec_ctrl
  import risc_pkg::*;
#(
  parameter int NREGS = 4,
  parameter int W     = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] instr,
  input  logic         instr_valid,
  output logic         instr_ready,
  output logic [W-1:0] alu_op1,
  output logic [W-1:0] alu_op2,
  output logic [2:0]   alu_sel,
  input  logic [W-1:0] alu_out,
  input  logic         alu_co,
  output logic [W-1:0] result,
  output logic         result_valid,
  input  logic         result_ready,
  output logic         carry_flag,
  output logic         busy
);

  state_t       state;
  state_t       next_state;
  logic [2:0]   op_q;
  logic [1:0]   rd_q;
  logic [1:0]   rs_q;
  logic [W-1:0] imm_q;
  logic         cf_q;
  logic [W-1:0] result_q;
  logic         result_valid_q;
  logic         armed;
  logic         accept;
  logic [1:0]   raddr_a;
  logic [W-1:0] rdata_a;
  logic [W-1:0] rdata_b;
  logic         wr_en;

  // Keeps instr_ready low while in reset and until the first edge after release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      armed <= 1'b0;
    end else begin
      armed <= 1'b1;
    end
  end

  assign instr_ready = armed && ((state == S_IDLE) || (state == S_IMM));
  assign accept      = instr_valid && instr_ready;
  assign busy        = (state != S_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE: begin
        if (accept) begin
          next_state = (instr[OP_MSB:OP_LSB] == OP_LDI) ? S_IMM : S_EXEC;
        end
      end
      S_IMM: begin
        if (accept) begin
          next_state = S_EXEC;
        end
      end
      S_EXEC: begin
        next_state = (op_q == OP_OUT) ? S_OUT : S_IDLE;
      end
      S_OUT: begin
        if (result_ready) begin
          next_state = S_IDLE;
        end
      end
      default: next_state = S_IDLE;
    endcase
  end

  // The immediate byte is latched raw; it is never decoded as an instruction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q  <= OP_ADD;
      rd_q  <= 2'd0;
      rs_q  <= 2'd0;
      imm_q <= '0;
    end else if (accept && (state == S_IDLE)) begin
      op_q <= instr[OP_MSB:OP_LSB];
      rd_q <= instr[RD_MSB:RD_LSB];
      rs_q <= instr[RS_MSB:RS_LSB];
    end else if (accept && (state == S_IMM)) begin
      imm_q <= instr;
    end
  end

  assign raddr_a = (op_q == OP_MOV) ? rs_q : rd_q;
  assign alu_op1 = (op_q == OP_LDI) ? imm_q : rdata_a;
  assign alu_op2 = rdata_b;
  assign alu_sel = op_q;
  assign wr_en   = (state == S_EXEC) && (op_q != OP_OUT);

  reg_file_4x8 #(
    .NREGS (NREGS),
    .W     (W),
    .AW    (2)
  ) u_regs (
    .clk     (clk),
    .rst_n   (rst_n),
    .raddr_a (raddr_a),
    .rdata_a (rdata_a),
    .raddr_b (rs_q),
    .rdata_b (rdata_b),
    .we      (wr_en),
    .waddr   (rd_q),
    .wdata   (alu_out)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cf_q <= 1'b0;
    end else if ((state == S_EXEC) && op_sets_cf(op_q)) begin
      cf_q <= alu_co;
    end
  end

  // Result is captured in the execute cycle and held until the consumer takes it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_q       <= '0;
      result_valid_q <= 1'b0;
    end else if ((state == S_EXEC) && (op_q == OP_OUT)) begin
      result_q       <= alu_out;
      result_valid_q <= 1'b1;
    end else if ((state == S_OUT) && result_ready) begin
      result_valid_q <= 1'b0;
    end
  end

  assign result       = result_q;
  assign result_valid = result_valid_q;
  assign carry_flag   = cf_q;

endmodule

// File: tb/tb_exec_ctrl.sv
// Self-checking bench for exec_ctrl with a behavioural ALU stand-in,
// a constant vector table, directed corner sequences and randomized traffic.
module tb_exec_ctrl;

  logic       clk;
  logic       rst_n;
  logic [7:0] instr;
  logic       instr_valid;
  logic       instr_ready;
  logic [7:0] alu_op1;
  logic [7:0] alu_op2;
  logic [2:0] alu_sel;
  logic [7:0] alu_out;
  logic       alu_co;
  logic [7:0] result;
  logic       result_valid;
  logic       result_ready;
  logic       carry_flag;
  logic       busy;

  int vectors;
  int miscompares;

  logic [7:0] m_regs [4];
  logic       m_cf;

  typedef struct {
    logic [7:0] ins;
    logic [7:0] imm;
    logic       chk_res;
    logic [7:0] exp_res;
    logic       chk_cf;
    logic       exp_cf;
  } vec_t;

  vec_t vecs[$];

  exec_ctrl #(.NREGS(4), .W(8)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .instr        (instr),
    .instr_valid  (instr_valid),
    .instr_ready  (instr_ready),
    .alu_op1      (alu_op1),
    .alu_op2      (alu_op2),
    .alu_sel      (alu_sel),
    .alu_out      (alu_out),
    .alu_co       (alu_co),
    .result       (result),
    .result_valid (result_valid),
    .result_ready (result_ready),
    .carry_flag   (carry_flag),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ALU stand-in: ASHL/DIV2 shift by one, NEG is two's complement, pass-through otherwise.
  always_comb begin
    {alu_co, alu_out} = {1'b0, alu_op1};
    case (alu_sel)
      3'b000: {alu_co, alu_out} = {1'b0, alu_op1} + {1'b0, alu_op2};
      3'b001: {alu_co, alu_out} = {alu_op1, 1'b0};
      3'b010: {alu_co, alu_out} = {1'b0, ~(alu_op1 ^ alu_op2)};
      3'b011: {alu_co, alu_out} = {alu_op1[0], alu_op1[7], alu_op1[7:1]};
      3'b110: {alu_co, alu_out} = {alu_op1 != 8'h00, 8'h00 - alu_op1};
      default: {alu_co, alu_out} = {1'b0, alu_op1};
    endcase
  end

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  task automatic modelReset();
    for (int i = 0; i < 4; i++) m_regs[i] = 8'h00;
    m_cf = 1'b0;
  endtask

  // Architectural effect of one instruction, computed with plain arithmetic.
  task automatic modelStep(input logic [7:0] b, input logic [7:0] imm, output logic [7:0] outv);
    int a, s, r;
    int rd, rs;
    rd = int'(b[4:3]);
    rs = int'(b[2:1]);
    a = int'(m_regs[rd]);
    s = int'(m_regs[rs]);
    outv = 8'h00;
    case (b[7:5])
      3'b000: begin r = a + s; m_regs[rd] = 8'(r % 256); m_cf = (r > 255); end
      3'b001: begin r = a * 2; m_regs[rd] = 8'(r % 256); m_cf = (a >= 128); end
      3'b010: begin m_regs[rd] = 8'(255 - (a ^ s)); m_cf = 1'b0; end
      3'b011: begin r = (a >= 128) ? (a / 2 + 128) : (a / 2); m_regs[rd] = 8'(r); m_cf = (a % 2 == 1); end
      3'b110: begin m_regs[rd] = 8'((256 - a) % 256); m_cf = (a != 0); end
      3'b100: m_regs[rd] = 8'(s);
      3'b101: m_regs[rd] = imm;
      default: outv = 8'(a);
    endcase
  endtask

  // Called at a falling edge; returns at the falling edge after acceptance.
  task automatic applyStimulus(input logic [7:0] b);
    int n;
    n = 0;
    instr = b;
    instr_valid = 1'b1;
    while (!instr_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!instr_ready) checkOutput("accept_timeout", {31'd0, instr_ready}, 32'd1);
    @(negedge clk);
    instr_valid = 1'b0;
  endtask

  task automatic takeResult(input int stall, output logic [7:0] got);
    int n;
    n = 0;
    while (!result_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!result_valid) checkOutput("result_valid_timeout", {31'd0, result_valid}, 32'd1);
    got = result;
    repeat (stall) @(negedge clk);
    result_ready = 1'b1;
    @(negedge clk);
    result_ready = 1'b0;
  endtask

  task automatic execInstr(input logic [7:0] b, input logic [7:0] imm, input int stall,
                           output logic [7:0] got, output logic [7:0] exp);
    applyStimulus(b);
    if (b[7:5] == 3'b101) applyStimulus(imm);
    modelStep(b, imm, exp);
    got = 8'h00;
    if (b[7:5] == 3'b111) takeResult(stall, got);
  endtask

  function automatic vec_t mk(input logic [7:0] ins, input logic [7:0] imm, input logic chk_res,
                              input logic [7:0] exp_res, input logic chk_cf, input logic exp_cf);
    vec_t v;
    v.ins = ins; v.imm = imm; v.chk_res = chk_res; v.exp_res = exp_res;
    v.chk_cf = chk_cf; v.exp_cf = exp_cf;
    return v;
  endfunction

  initial begin
    logic [7:0] got, exp, held, b, imm;
    vectors = 0;
    miscompares = 0;
    rst_n = 1'b0;
    instr = 8'h00;
    instr_valid = 1'b0;
    result_ready = 1'b0;
    modelReset();

    vecs.push_back(mk(8'hE0, 8'h00, 1, 8'h00, 1, 1'b0));
    vecs.push_back(mk(8'hE8, 8'h00, 1, 8'h00, 0, 1'b0));
    vecs.push_back(mk(8'hF0, 8'h00, 1, 8'h00, 0, 1'b0));
    vecs.push_back(mk(8'hF8, 8'h00, 1, 8'h00, 1, 1'b0));
    vecs.push_back(mk(8'hA0, 8'hF0, 0, 8'h00, 0, 1'b0));
    vecs.push_back(mk(8'hA8, 8'h20, 0, 8'h00, 0, 1'b0));
    vecs.push_back(mk(8'h02, 8'h00, 0, 8'h00, 0, 1'b0));
    vecs.push_back(mk(8'hE0, 8'h00, 1, 8'h10, 1, 1'b1));
    vecs.push_back(mk(8'hB0, 8'h05, 0, 8'h00, 0, 1'b0));
    vecs.push_back(mk(8'hD0, 8'h00, 0, 8'h00, 0, 1'b0));
    vecs.push_back(mk(8'hF0, 8'h00, 1, 8'hFB, 0, 1'b0));
    vecs.push_back(mk(8'hB8, 8'hF0, 0, 8'h00, 0, 1'b0));
    vecs.push_back(mk(8'hA8, 8'h20, 0, 8'h00, 0, 1'b0));
    vecs.push_back(mk(8'h5A, 8'h00, 0, 8'h00, 0, 1'b0));
    vecs.push_back(mk(8'h86, 8'h00, 0, 8'h00, 0, 1'b0));
    vecs.push_back(mk(8'hE0, 8'h00, 1, 8'h2F, 1, 1'b0));

    repeat (3) @(negedge clk);
    checkOutput("rst_instr_ready", {31'd0, instr_ready}, 32'd0);
    checkOutput("rst_busy", {31'd0, busy}, 32'd0);
    checkOutput("rst_result_valid", {31'd0, result_valid}, 32'd0);
    checkOutput("rst_carry", {31'd0, carry_flag}, 32'd0);
    checkOutput("rst_alu_sel", {29'd0, alu_sel}, 32'd0);
    checkOutput("rst_alu_op1", {24'd0, alu_op1}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("post_rst_instr_ready", {31'd0, instr_ready}, 32'd1);

    for (int i = 0; i < vecs.size(); i++) begin
      execInstr(vecs[i].ins, vecs[i].imm, i % 3, got, exp);
      if (vecs[i].chk_res) checkOutput($sformatf("table_result[%0d]", i), {24'd0, got}, {24'd0, vecs[i].exp_res});
      if (vecs[i].chk_cf) checkOutput($sformatf("table_cf[%0d]", i), {31'd0, carry_flag}, {31'd0, vecs[i].exp_cf});
    end

    // OUT backpressure with the next ADD already waiting on the input.
    applyStimulus(8'hE0);
    modelStep(8'hE0, 8'h00, exp);
    @(negedge clk);
    checkOutput("bp_result_valid", {31'd0, result_valid}, 32'd1);
    held = result;
    checkOutput("bp_result", {24'd0, held}, {24'd0, exp});
    instr = 8'h02;
    instr_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput($sformatf("bp_stable[%0d]", i), {24'd0, result}, {24'd0, held});
      checkOutput($sformatf("bp_ready_low[%0d]", i), {31'd0, instr_ready}, 32'd0);
    end
    result_ready = 1'b1;
    @(negedge clk);
    result_ready = 1'b0;
    checkOutput("bp_valid_cleared", {31'd0, result_valid}, 32'd0);
    checkOutput("bp_idle_ready", {31'd0, instr_ready}, 32'd1);
    @(negedge clk);
    instr_valid = 1'b0;
    checkOutput("bp_add_accepted", {31'd0, busy}, 32'd1);
    modelStep(8'h02, 8'h00, exp);
    execInstr(8'hE0, 8'h00, 0, got, exp);
    checkOutput("bp_add_result", {24'd0, got}, {24'd0, exp});

    // LDI with a gap before the immediate.
    applyStimulus(8'hA0);
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("ldi_gap_busy[%0d]", i), {31'd0, busy}, 32'd1);
      @(negedge clk);
    end
    applyStimulus(8'h7F);
    modelStep(8'hA0, 8'h7F, exp);
    execInstr(8'hE0, 8'h00, 1, got, exp);
    checkOutput("ldi_gap_result", {24'd0, got}, 32'h7F);

    // Reset while ADD R0,R1 is executing; the carry it would produce must not land.
    execInstr(8'hA0, 8'h01, 0, got, exp);
    execInstr(8'hA8, 8'hFF, 0, got, exp);
    applyStimulus(8'h02);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    modelReset();
    checkOutput("mid_rst_busy", {31'd0, busy}, 32'd0);
    checkOutput("mid_rst_carry", {31'd0, carry_flag}, 32'd0);
    checkOutput("mid_rst_result_valid", {31'd0, result_valid}, 32'd0);
    execInstr(8'hE0, 8'h00, 0, got, exp);
    checkOutput("mid_rst_r0", {24'd0, got}, 32'h00);
    execInstr(8'hE8, 8'h00, 0, got, exp);
    checkOutput("mid_rst_r1", {24'd0, got}, 32'h00);

    // Randomized traffic against the model.
    for (int i = 0; i < 120; i++) begin
      b = 8'($urandom);
      imm = 8'($urandom);
      execInstr(b, imm, int'($urandom_range(0, 3)), got, exp);
      if (b[7:5] == 3'b111) checkOutput($sformatf("rand_out[%0d]", i), {24'd0, got}, {24'd0, exp});
      else if ((i % 8) == 0) checkOutput($sformatf("rand_cf[%0d]", i), {31'd0, carry_flag}, {31'd0, m_cf});
    end
    for (int r = 0; r < 4; r++) begin
      b = {3'b111, 2'(r), 3'b000};
      execInstr(b, 8'h00, 0, got, exp);
      checkOutput($sformatf("final_r%0d", r), {24'd0, got}, {24'd0, exp});
    end
    checkOutput("final_cf", {31'd0, carry_flag}, {31'd0, m_cf});

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
